imem_fetch_responder: RTL and testbench

//  Instruction-memory responder for the fetch path: accepts word-fetch requests

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_skid_fifo.sv | 46 ++++
 rtl/imem_fetch_responder.sv | 121 ++++++++++++
 tb/tb_imem_fetch_responder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch responder.
//   fetch_fault_e : fault code carried with each response
//   fetch_rsp_t   : one response record (instruction, request address, fault)
//   word_index    : byte address -> RAM word index relative to a base address
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_OK       = 2'b00,
    FETCH_MISALIGN = 2'b01,
    FETCH_RANGE    = 2'b10
  } fetch_fault_e;

  typedef struct packed {
    logic [31:0]  instr;
    logic [31:0]  addr;
    fetch_fault_e fault;
  } fetch_rsp_t;

  // Addresses below base wrap to a huge index; the caller checks that case too.
  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry FIFO of fetch responses sitting behind the RAM read stage.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   flush            drop every buffered entry at this edge
//   push, push_data  enqueue one response
//   pop              dequeue the head
//   head             oldest entry (valid when !empty)
//   count, empty     occupancy
module fetch_skid_fifo
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  fetch_rsp_t push_data,
  input  logic       pop,
  output fetch_rsp_t head,
  output logic [1:0] count,
  output logic       empty
);

  fetch_rsp_t slot [2];
  logic       wr_ptr;
  logic       rd_ptr;

  always_ff @(posedge clk) begin
    if (push) slot[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign head  = slot[rd_ptr];
  assign empty = (count == 2'd0);

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder: in-order word fetches from an inferred
// single-port RAM (1-cycle read) with fault tagging, branch flush and a loader
// write port. At most two responses outstanding (read stage + skid FIFO).
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   req_valid/req_ready/req_addr     fetch request channel
//   rsp_valid/rsp_ready              response channel handshake
//   rsp_instr/rsp_addr/rsp_fault     response payload
//   flush                            discard in-flight/buffered responses
//   prog_we/prog_addr/prog_data      loader write port (has priority)
module imem_fetch_responder
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic [31:0] rsp_addr,
  output logic [1:0]  rsp_fault,
  input  logic        flush,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_data
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]  mem [DEPTH_WORDS];
  logic [31:0]  ram_q;

  logic [31:0]  req_idx, prog_idx;
  fetch_fault_e req_fault;
  logic         prog_ok;
  logic         accept;

  logic         rd_valid;
  logic [31:0]  rd_addr;
  fetch_fault_e rd_fault;
  fetch_rsp_t   rd_rsp;

  fetch_rsp_t   fifo_head, rsp_sel;
  logic [1:0]   fifo_count, outstanding;
  logic         fifo_empty, fifo_push, fifo_pop, rsp_pop;

  assign req_idx  = word_index(req_addr, BASE_ADDR);
  assign prog_idx = word_index(prog_addr, BASE_ADDR);

  // Misalignment wins over range so a stray low-bit address is always reported as such.
  always_comb begin
    req_fault = FETCH_OK;
    if (req_addr[1:0] != 2'b00)
      req_fault = FETCH_MISALIGN;
    else if (req_addr < BASE_ADDR || req_idx >= DEPTH_WORDS)
      req_fault = FETCH_RANGE;
  end

  assign prog_ok = prog_we && (prog_addr[1:0] == 2'b00) &&
                   (prog_addr >= BASE_ADDR) && (prog_idx < DEPTH_WORDS);

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (prog_ok) mem[prog_idx[AW-1:0]] <= prog_data;
    if (accept && req_fault == FETCH_OK) ram_q <= mem[req_idx[AW-1:0]];
  end

  // Read stage holds a tag for exactly one cycle; afterwards the entry has
  // either been consumed directly or moved into the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= accept;
    end
    if (accept) begin
      rd_addr  <= req_addr;
      rd_fault <= req_fault;
    end
  end

  assign rd_rsp.instr = (rd_fault == FETCH_OK) ? ram_q : NOP_WORD;
  assign rd_rsp.addr  = rd_addr;
  assign rd_rsp.fault = rd_fault;

  // FIFO entries are older than the read stage, so it is presented only when the FIFO is empty.
  assign rsp_sel   = fifo_empty ? rd_rsp : fifo_head;
  assign rsp_valid = !fifo_empty || rd_valid;
  assign rsp_instr = rsp_sel.instr;
  assign rsp_addr  = rsp_sel.addr;
  assign rsp_fault = rsp_sel.fault;

  assign rsp_pop   = rsp_valid && rsp_ready;
  assign fifo_pop  = rsp_pop && !fifo_empty;
  assign fifo_push = rd_valid && !flush && !(fifo_empty && rsp_ready);

  fetch_skid_fifo u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (fifo_push),
    .push_data (rd_rsp),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign outstanding = fifo_count + {1'b0, rd_valid};

  // rsp_ready reaches req_ready only through the popped-slot term.
  assign req_ready = !rst && !prog_we && ((outstanding < 2'd2) || rsp_pop);

endmodule

// File: tb/tb_imem_fetch_responder.sv
module tb_imem_fetch_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_instr, rsp_addr;
  logic [1:0]  rsp_fault;
  logic        flush, prog_we;
  logic [31:0] prog_addr, prog_data;

  always #5 clk = ~clk;

  imem_fetch_responder #(
    .DEPTH_WORDS (1024),
    .BASE_ADDR   (32'h0000_0000),
    .NOP_WORD    (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_addr  (rsp_addr),
    .rsp_fault (rsp_fault),
    .flush     (flush),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] got_addr[$];
  logic [31:0] got_instr[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [1:0]  fault;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [31:0] a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    step;
    prog_we = 1'b0;
  endtask

  // Runs a bounded number of cycles with rsp_ready=1, recording every
  // handshaken response and dropping req_valid once the pending request is taken.
  task automatic drain(input int cycles);
    logic acc;
    got_addr.delete();
    got_instr.delete();
    rsp_ready = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      #1;
      if (rsp_valid) begin
        got_addr.push_back(rsp_addr);
        got_instr.push_back(rsp_instr);
      end
      acc = req_valid && req_ready;
      step;
      if (acc) req_valid = 1'b0;
    end
  endtask

  function automatic logic [31:0] got_at(input int i);
    return (got_addr.size() > i) ? got_addr[i] : 32'hFFFF_FFFF;
  endfunction

  // Accepts two requests while stalled so that two responses are outstanding.
  task automatic fill_two;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h400;
    step;
    req_addr = 32'h404;
    step;
    req_valid = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b1; req_addr = 32'h0; rsp_ready = 1'b0;
    flush = 1'b0; prog_we = 1'b0; prog_addr = 32'h0; prog_data = 32'h0;

    vecs[0] = '{32'h0000_0400, 32'hDEAD_BEEF, 2'b00};
    vecs[1] = '{32'h0000_0402, 32'h0000_0000, 2'b01};
    vecs[2] = '{32'h0000_1000, 32'h0000_0000, 2'b10};
    vecs[3] = '{32'h0000_0000, 32'h1111_1111, 2'b00};
    vecs[4] = '{32'h0000_0FFC, 32'h2222_2222, 2'b00};
    vecs[5] = '{32'h0000_1002, 32'h0000_0000, 2'b01};
    vecs[6] = '{32'h0000_0404, 32'h3333_3333, 2'b00};
    vecs[7] = '{32'h0000_0800, 32'h5555_5555, 2'b00};

    step; step; step;
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_req_ready", {31'b0, req_ready}, 32'd0);
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_reset_req_ready", {31'b0, req_ready}, 32'd1);

    // loader has priority over a pending request
    req_valid = 1'b1; req_addr = 32'h400;
    prog_we = 1'b1; prog_addr = 32'h400; prog_data = 32'hDEAD_BEEF;
    #1;
    chk("prog_blocks_req", {31'b0, req_ready}, 32'd0);
    step;
    prog_we = 1'b0; req_valid = 1'b0;
    prog(32'h0000_0000, 32'h1111_1111);
    prog(32'h0000_0FFC, 32'h2222_2222);
    prog(32'h0000_0404, 32'h3333_3333);
    prog(32'h0000_0408, 32'h4444_4444);
    prog(32'h0000_0800, 32'h5555_5555);
    prog(32'h0000_1000, 32'hBAD0_0001);   // out of range: would alias word 0
    prog(32'h0000_0001, 32'hBAD0_0002);   // misaligned: would hit word 0
    #1;

    for (int i = 0; i < 8; i++) begin
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_addr = vecs[i].addr;
      #1;
      chk($sformatf("vec%0d_req_ready", i), {31'b0, req_ready}, 32'd1);
      step;
      req_valid = 1'b0;
      #1;
      chk($sformatf("vec%0d_rsp_valid", i), {31'b0, rsp_valid}, 32'd1);
      chk($sformatf("vec%0d_instr", i), rsp_instr, vecs[i].instr);
      chk($sformatf("vec%0d_addr", i), rsp_addr, vecs[i].addr);
      chk($sformatf("vec%0d_fault", i), {30'b0, rsp_fault}, {30'b0, vecs[i].fault});
      step;
      chk($sformatf("vec%0d_consumed", i), {31'b0, rsp_valid}, 32'd0);
    end

    // back-to-back under backpressure: capacity two, then in-order release
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h400;
    #1;
    chk("bp_accept0", {31'b0, req_ready}, 32'd1);
    step;
    req_addr = 32'h404;
    #1;
    chk("bp_accept1", {31'b0, req_ready}, 32'd1);
    step;
    req_addr = 32'h408;
    #1;
    chk("bp_full", {31'b0, req_ready}, 32'd0);
    chk("bp_head", rsp_addr, 32'h400);
    step;
    chk("bp_still_full", {31'b0, req_ready}, 32'd0);
    chk("bp_head_stable", rsp_addr, 32'h400);
    chk("bp_instr_stable", rsp_instr, 32'hDEAD_BEEF);
    drain(8);
    chk("bp_count", got_addr.size(), 32'd3);
    chk("bp_order0", got_at(0), 32'h400);
    chk("bp_order1", got_at(1), 32'h404);
    chk("bp_order2", got_at(2), 32'h408);
    chk("bp_instr2", (got_instr.size() > 2) ? got_instr[2] : 32'hFFFF_FFFF, 32'h4444_4444);

    // flush with two buffered; new request waits until room frees
    fill_two;
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'h800;
    #1;
    chk("flush_full_ready", {31'b0, req_ready}, 32'd0);
    step;
    flush = 1'b0;
    #1;
    chk("flush_clears", {31'b0, rsp_valid}, 32'd0);
    drain(6);
    chk("flush_count", got_addr.size(), 32'd1);
    chk("flush_new_addr", got_at(0), 32'h800);
    chk("flush_new_instr", (got_instr.size() > 0) ? got_instr[0] : 32'hFFFF_FFFF, 32'h5555_5555);

    // flush with a request accepted the same cycle: that request survives
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h400;
    step;
    flush = 1'b1; req_addr = 32'h408;
    #1;
    chk("flush_same_ready", {31'b0, req_ready}, 32'd1);
    step;
    flush = 1'b0; req_valid = 1'b0;
    #1;
    chk("flush_same_valid", {31'b0, rsp_valid}, 32'd1);
    chk("flush_same_addr", rsp_addr, 32'h408);
    chk("flush_same_instr", rsp_instr, 32'h4444_4444);
    drain(4);
    chk("flush_same_count", got_addr.size(), 32'd1);

    // flush together with a handshake: head taken, rest dropped
    fill_two;
    rsp_ready = 1'b1; flush = 1'b1;
    #1;
    chk("flush_hs_head", rsp_addr, 32'h400);
    step;
    flush = 1'b0; rsp_ready = 1'b0;
    #1;
    chk("flush_hs_empty", {31'b0, rsp_valid}, 32'd0);

    // read-after-write through the loader
    req_valid = 1'b1; req_addr = 32'h404;
    prog_we = 1'b1; prog_addr = 32'h404; prog_data = 32'h6666_6666;
    #1;
    chk("raw_blocked", {31'b0, req_ready}, 32'd0);
    step;
    prog_we = 1'b0; rsp_ready = 1'b1;
    #1;
    chk("raw_ready", {31'b0, req_ready}, 32'd1);
    step;
    req_valid = 1'b0;
    #1;
    chk("raw_instr", rsp_instr, 32'h6666_6666);
    step;

    // reset with two outstanding
    fill_two;
    rst = 1'b1; req_valid = 1'b1; req_addr = 32'h0;
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    step;
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    step;
    rst = 1'b0;
    #1;
    chk("rst_release_ready", {31'b0, req_ready}, 32'd1);
    step;
    req_valid = 1'b0;
    #1;
    chk("rst_fresh_valid", {31'b0, rsp_valid}, 32'd1);
    chk("rst_fresh_instr", rsp_instr, 32'h1111_1111);
    chk("rst_fresh_addr", rsp_addr, 32'h0);
    drain(4);
    chk("rst_fresh_count", got_addr.size(), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
